// File: rtl/stream_demux_4.sv
// stream_demux_4: 1-to-4 routing demultiplexer with valid/ready handshakes.
// One upstream beat goes to the channel chosen by up_sel. Each channel has
// its own one-entry output register, so a stalled consumer blocks only
// beats addressed to its own channel.
// Optional feature macro: STREAM_DEMUX_XFER_CNT_EN adds an 8-bit wrapping
// transfer counter per channel on xfer_cnt. Without it, xfer_cnt is 0.
module stream_demux_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [1:0]       up_sel,
  output logic [3:0]       dn_valid,
  input  logic [3:0]       dn_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [31:0]      xfer_cnt
);

  logic [3:0]       buf_valid;
  logic [WIDTH-1:0] buf_data [4];
  logic [3:0]       load;
  logic [3:0]       drain;

  // Ready looks only at the indexed channel; load/drain strobes per channel.
  always_comb begin
    up_ready       = ~buf_valid[up_sel] | dn_ready[up_sel];
    load           = 4'b0000;
    if (up_valid && up_ready) begin
      load[up_sel] = 1'b1;
    end
    drain          = buf_valid & dn_ready;
  end

  // Per-channel output registers; a load on the draining edge keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= up_data;
        end else if (drain[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign dn_valid = buf_valid;
  assign y0       = buf_data[0];
  assign y1       = buf_data[1];
  assign y2       = buf_data[2];
  assign y3       = buf_data[3];

`ifdef STREAM_DEMUX_XFER_CNT_EN
  logic [7:0] cnt [4];

  // Count downstream handshakes per channel; natural 8-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  assign xfer_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  assign xfer_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_stream_demux_4.sv
// Directed self-checking bench for stream_demux_4 (WIDTH = 4).
// Counter expectations follow STREAM_DEMUX_XFER_CNT_EN: with the macro the
// hand-computed counts apply, without it xfer_cnt must read 0.
module tb_stream_demux_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_data;
  logic [1:0] up_sel;
  logic [3:0] dn_valid;
  logic [3:0] dn_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [31:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  stream_demux_4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
    .dn_valid(dn_valid), .dn_ready(dn_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Producer rule: an offered but unaccepted beat keeps data and sel stable.
  logic       hold_pend = 1'b0;
  logic [3:0] hold_data;
  logic [1:0] hold_sel;
  always @(posedge clk) begin
    if (!rst && hold_pend === 1'b1) begin
      assert (up_data === hold_data && up_sel === hold_sel)
        else $error("protocol FAIL: stalled beat changed data/sel");
    end
    hold_pend <= up_valid & ~up_ready;
    hold_data <= up_data;
    hold_sel  <= up_sel;
  end

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef STREAM_DEMUX_XFER_CNT_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_valid = 1'b1; up_sel = 2'd2; up_data = 4'h3; dn_ready = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (dn_valid !== 4'b0000) begin errors++; $display("FAIL reset_dn_valid cyc%0d got %b want 0000", c, dn_valid); end
      checks++;
      if ({y3, y2, y1, y0} !== 16'h0) begin errors++; $display("FAIL reset_y cyc%0d got %h want 0000", c, {y3, y2, y1, y0}); end
      checks++;
      if (xfer_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt cyc%0d got %h want 0", c, xfer_cnt); end
    end
    rst = 1'b0; up_valid = 1'b0;
    tick();
    checks++;
    if (dn_valid !== 4'b0000 || {y3, y2, y1, y0} !== 16'h0 || xfer_cnt !== 32'h0) begin
      errors++; $display("FAIL after_reset got dn_valid=%b y=%h cnt=%h want 0", dn_valid, {y3, y2, y1, y0}, xfer_cnt);
    end
  endtask

  task automatic test_single_beat();
    up_valid = 1'b1; up_sel = 2'd1; up_data = 4'hA; dn_ready = 4'b0000;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL single_ready_empty got %b want 1", up_ready); end
    tick();
    checks++;
    if (dn_valid !== 4'b0010) begin errors++; $display("FAIL single_dn_valid got %b want 0010", dn_valid); end
    checks++;
    if (y1 !== 4'hA) begin errors++; $display("FAIL single_y1 got %h want a", y1); end
    up_data = 4'hB;
    #1;
    checks++;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL single_ready_full got %b want 0", up_ready); end
    up_valid = 1'b0;
    up_sel = 2'd0;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL sel_switch_ch0 got %b want 1", up_ready); end
    up_sel = 2'd1;
    #1;
    checks++;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL sel_switch_ch1 got %b want 0", up_ready); end
    dn_ready = 4'b0010;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL ready_full_draining got %b want 1", up_ready); end
    tick();
    checks++;
    if (dn_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got %b want 0000", dn_valid); end
    checks++;
    if (y1 !== 4'hA) begin errors++; $display("FAIL single_y1_hold got %h want a", y1); end
    checks++;
    if (xfer_cnt !== cnt_exp(32'h0000_0100)) begin errors++; $display("FAIL single_cnt got %h want %h", xfer_cnt, cnt_exp(32'h0000_0100)); end
    dn_ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    dn_ready = 4'b1111; up_sel = 2'd3; up_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      up_data = k[3:0];
      #1;
      checks++;
      if (up_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat%0d got %b want 1", k, up_ready); end
      tick();
      checks++;
      if (y3 !== k[3:0] || dn_valid[3] !== 1'b1) begin
        errors++; $display("FAIL b2b_y3 beat%0d got y3=%h v=%b want y3=%h v=1", k, y3, dn_valid[3], k[3:0]);
      end
    end
    up_valid = 1'b0;
    tick();
    checks++;
    if (dn_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drained got %b want 0000", dn_valid); end
    checks++;
    if (xfer_cnt !== cnt_exp(32'h0400_0100)) begin errors++; $display("FAIL b2b_cnt got %h want %h", xfer_cnt, cnt_exp(32'h0400_0100)); end
    dn_ready = 4'b0000;
  endtask

  task automatic test_no_hol();
    up_valid = 1'b1; up_sel = 2'd0; up_data = 4'h9;
    tick();
    checks++;
    if (dn_valid !== 4'b0001 || y0 !== 4'h9) begin errors++; $display("FAIL hol_fill0 got v=%b y0=%h want 0001/9", dn_valid, y0); end
    up_sel = 2'd2; up_data = 4'h5;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL hol_ready_ch2 got %b want 1", up_ready); end
    tick();
    checks++;
    if (dn_valid !== 4'b0101) begin errors++; $display("FAIL hol_dn_valid got %b want 0101", dn_valid); end
    checks++;
    if (y2 !== 4'h5 || y0 !== 4'h9) begin errors++; $display("FAIL hol_data got y2=%h y0=%h want 5/9", y2, y0); end
    up_valid = 1'b0;
  endtask

  task automatic test_drain_refill();
    dn_ready = 4'b0001; up_valid = 1'b1; up_sel = 2'd0; up_data = 4'h7;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL refill_ready got %b want 1", up_ready); end
    tick();
    checks++;
    if (dn_valid !== 4'b0101 || y0 !== 4'h7) begin errors++; $display("FAIL refill7 got v=%b y0=%h want 0101/7", dn_valid, y0); end
    up_data = 4'h8;
    tick();
    checks++;
    if (dn_valid !== 4'b0101 || y0 !== 4'h8) begin errors++; $display("FAIL refill8 got v=%b y0=%h want 0101/8", dn_valid, y0); end
    up_valid = 1'b0; dn_ready = 4'b0000;
    tick();
    checks++;
    if (dn_valid !== 4'b0101 || y0 !== 4'h8) begin errors++; $display("FAIL refill_hold got v=%b y0=%h want 0101/8", dn_valid, y0); end
    checks++;
    if (xfer_cnt !== cnt_exp(32'h0400_0102)) begin errors++; $display("FAIL refill_cnt got %h want %h", xfer_cnt, cnt_exp(32'h0400_0102)); end
  endtask

  task automatic test_reset_mid();
    up_valid = 1'b1; up_sel = 2'd1; up_data = 4'h1;
    tick();
    up_sel = 2'd3; up_data = 4'h3;
    tick();
    up_valid = 1'b0;
    #1;
    checks++;
    if (dn_valid !== 4'b1111) begin errors++; $display("FAIL mid_full got %b want 1111", dn_valid); end
    rst = 1'b1; dn_ready = 4'b1111; up_valid = 1'b1; up_sel = 2'd2; up_data = 4'hF;
    tick();
    checks++;
    if (dn_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid got %b want 0000", dn_valid); end
    checks++;
    if ({y3, y2, y1, y0} !== 16'h0 || xfer_cnt !== 32'h0) begin
      errors++; $display("FAIL mid_rst_state got y=%h cnt=%h want 0/0", {y3, y2, y1, y0}, xfer_cnt);
    end
    rst = 1'b0; up_valid = 1'b0; dn_ready = 4'b0000;
    tick();
  endtask

  task automatic test_cnt_wrap();
    dn_ready = 4'b0001; up_valid = 1'b1; up_sel = 2'd0;
    for (int k = 0; k < 255; k++) begin
      up_data = k[3:0];
      tick();
    end
    up_valid = 1'b0;
    tick();
    checks++;
    if (xfer_cnt !== cnt_exp(32'h0000_00FF)) begin errors++; $display("FAIL wrap_255 got %h want %h", xfer_cnt, cnt_exp(32'h0000_00FF)); end
    checks++;
    if (dn_valid !== 4'b0000 || y0 !== 4'hE) begin errors++; $display("FAIL wrap_stream got v=%b y0=%h want 0000/e", dn_valid, y0); end
    up_valid = 1'b1; up_data = 4'h6;
    tick();
    checks++;
    if (y0 !== 4'h6 || dn_valid !== 4'b0001) begin errors++; $display("FAIL wrap_last got v=%b y0=%h want 0001/6", dn_valid, y0); end
    up_valid = 1'b0;
    tick();
    checks++;
    if (xfer_cnt !== 32'h0) begin errors++; $display("FAIL wrap_0 got %h want 0", xfer_cnt); end
    dn_ready = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_no_hol();
    test_drain_refill();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_4.md
Name: stream_demux_4

Overview:
4-way routing demultiplexer with valid/ready handshakes; the counterpart of the indexed 4:1 mux.
- Takes one upstream beat plus a 2-bit channel index and delivers the beat to exactly one of four downstream channels.
- Each channel has a one-entry output register, so a stalled channel never corrupts or blocks data already held in another channel.
- Sits between a single producer and four independent consumers.

Parameters:
WIDTH, 4, data width in bits of the upstream and every downstream channel.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
up_valid  input  1  upstream beat present.
up_ready  output  1  block can accept the beat for the currently indexed channel.
up_data  input  WIDTH  upstream payload.
up_sel  input  2  destination channel index, 0..3.
dn_valid  output  4  bit i: channel i register holds a beat.
dn_ready  input  4  bit i: consumer i accepts a beat this cycle.
y0, y1, y2, y3  output  WIDTH  channel payloads, each driven from its own register.
xfer_cnt  output  32  per-channel transfer counters; channel i in bits [8i+7:8i] (see Optional Feature).

Behaviour:
- State per channel i: buf_valid[i] and buf_data[i]. dn_valid[i] = buf_valid[i]; y_i = buf_data[i].
- Reset, when rst is high at a clock edge:
  - buf_valid = 0 and all buf_data = 0, so y0..y3 = 0 and dn_valid = 4'b0000.
  - xfer_cnt = 0.
  - Any beat held at the time is discarded.
  - Reset has priority over any simultaneous handshake.
- up_ready is combinational: up_ready = ~buf_valid[up_sel] | dn_ready[up_sel].
  - It depends only on the indexed channel and does not depend on up_valid.
- Upstream accept (up_valid & up_ready at the edge): buf_data[up_sel] <= up_data and buf_valid[up_sel] <= 1.
  - Latency is 1 cycle: the beat appears on y_sel / dn_valid[sel] the cycle after acceptance.
- Downstream handshake on channel i (buf_valid[i] & dn_ready[i] at the edge): buf_valid[i] <= 0, unless the same edge also accepts a new beat for channel i.
  - In that case the register reloads and buf_valid[i] stays 1.
  - Full throughput is therefore 1 beat/cycle per channel when dn_ready[i] is held high.
- Channels are independent:
  - Channel i may drain on the same edge that another channel loads.
  - All four channels may drain on one edge.
- When buf_valid[i] = 0, y_i holds the last loaded value; it is not cleared except by reset.
- Upstream protocol rule: while up_valid = 1 and the beat is not accepted, the producer holds up_data and up_sel stable.
  - Violating this is illegal stimulus; the bench asserts it, and the block does not check it.
- A full, stalled channel (buf_valid = 1, dn_ready = 0) deasserts up_ready only while up_sel points at it.
  - Changing up_sel while up_valid is low immediately reflects the new channel's status.
- Ordering: beats routed to the same channel emerge in acceptance order. No ordering is defined across channels.
- No combinational path from up_valid or up_data to any downstream output.

Optional Feature:
Macro: STREAM_DEMUX_XFER_CNT_EN.
- Defined: xfer_cnt holds one 8-bit counter per channel.
  - The counter increments by 1 on each downstream handshake of that channel.
  - It wraps 255 -> 0 and resets to 0.
  - It updates on the same edge as the handshake.
- Undefined: the counter registers are not built and xfer_cnt is tied to 32'h0. All other behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles with up_valid=1, up_sel=2 -> dn_valid=4'b0000, y0..y3=0 and xfer_cnt=0 during and after reset.
2. Single beat: up_data=4'hA, up_sel=1, dn_ready=0 for one accept cycle -> next cycle dn_valid=4'b0010 and y1=4'hA. Then up_sel=1 with up_valid=1 -> up_ready=0. Then dn_ready[1]=1 -> dn_valid[1] clears next cycle.
3. Back-to-back streaming: dn_ready=4'b1111, up_sel=3, up_data 1,2,3,4 on consecutive cycles -> up_ready stays 1 and y3 shows 1,2,3,4 one cycle later with dn_valid[3]=1 throughout. With the macro, xfer_cnt[31:24]=4 afterwards.
4. No head-of-line blocking: fill channel 0 with dn_ready[0]=0, then send 4'h5 to channel 2 -> accepted immediately, y2=4'h5, and y0 keeps its value.
5. Simultaneous drain and refill on channel 0: buf full with 4'h7, dn_ready[0]=1, upstream sends 4'h8 to channel 0 on the same edge -> dn_valid[0] stays 1 and y0=4'h8 next cycle.
6. Reset mid-operation: all four channels full, assert rst for one cycle -> all dn_valid drop to 0 next cycle. With the macro, a counter preloaded to 255 wraps to 0 on the next handshake.
